cpu_csr_file: RTL
=================

Name: cpu_csr_file

Overview:
Parametrised supervisor CSR file for the CPU core. It supports configurable counter width and a configurable number of hardware performance counters. It provides read-modify-write CSR ops, direct/vectored trap entry, an interrupt pending/enable path with a stimecmp timer interrupt, and counter access gating via scounteren. It sits beside the decode/execute stage: execute drives CSR ops, and the trap unit consumes handler/return addresses and the interrupt request.

Parameters:
CNT_WIDTH, 64, width of cycle/time/instret/hpm counters (legal 33..64); high-half reads are zero-extended.
HPM_COUNT, 4, number of hpmcounterN implemented (0..29), mapped at N = 3..3+HPM_COUNT-1.
VECTORED, 1, if 1 stvec mode 01 (vectored) is legal; if 0, the mode field is hard-wired to 00.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
addr  in  12  CSR address
op  in  2  00 none, 01 write, 10 set, 11 clear
wr_data  in  32  operand for op
rd_data  out  32  current CSR value (combinational, pre-op)
access_ok  out  1  access legal; when 0, execute raises illegal-instruction and no write occurs
inst_retire  in  1  one instruction retired this cycle
timer_tick  in  1  level from timer; rising edge increments time
hpm_event  in  HPM_COUNT  per-counter increment enables
ext_irq  in  1  external interrupt level
trap  in  1  trap entry this cycle
trap_cause  in  32  scause value; bit 31 = interrupt
trap_pc  in  32  faulting/interrupted PC
trap_value  in  32  stval value
trap_ret  in  1  sret executed
handler_addr  out  32  trap target, derived from stvec and trap_cause
return_addr  out  32  sepc
irq_pending  out  1  enabled interrupt awaiting trap
irq_cause  out  32  cause to present on trap_cause when taking irq_pending
supervisor_mode  out  1  1 = S-mode, 0 = U-mode

Behaviour:
- Clocking/reset: single clock, clk. Reset is synchronous and active-high, and it wins over every other input in the same cycle.
- Reset values: all counters, sstatus, sie, SSIP, stvec, sscratch, sepc, scause, stval, scounteren = 0; stimecmp = all ones; supervisor_mode = 1; timer edge register = 0.
- Implemented addresses:
  - cycle C00/C80, time C01/C81, instret C02/C82, hpmcounterN C0N/C8N
  - sstatus 100, sie 104, stvec 105, scounteren 106, sscratch 140, sepc 141, scause 142, stval 143, sip 144
  - stimecmp 14D, stimecmph 15D
- access_ok = 0 on any of:
  - unimplemented address
  - addr[9:8]=01 while in U-mode
  - op != 00 to addr[11:10]=11 (read-only space)
  - U-mode read of counter k with scounteren[k]=0 (k = 0 cycle, 1 time, 2 instret, N hpm)
- Op semantics: new = wr_data (write), old|wr_data (set), old&~wr_data (clear). The value is committed at the next clk edge and only when access_ok=1.
- Write masks (WARL), other bits read 0:
  - sstatus: bits 1 SIE, 5 SPIE, 8 SPP
  - sie: bits 1, 5, 9
  - sip: bit 1 SSIP writable; bit 5 STIP reads (time >= stimecmp); bit 9 SEIP reads ext_irq
  - sepc: bit 0 forced 0
  - scounteren: bits [2+HPM_COUNT:0]
- stvec mode WARL: a write with mode 1x, or mode 01 when VECTORED=0, stores mode 00.
- handler_addr: combinational from the current stvec and trap_cause.
  - Mode 00: {base,00}.
  - Mode 01 with trap_cause[31]=1: {base,00} + 4*trap_cause[4:0].
  - Otherwise: {base,00}.
- Trap entry (trap=1):
  - sepc<=trap_pc&~1, scause<=trap_cause, stval<=trap_value
  - SPP<=supervisor_mode, SPIE<=SIE, SIE<=0, supervisor_mode<=1
  - Trap has priority over a same-cycle software write to these registers. Other CSRs still accept the write.
- trap_ret (ignored if trap=1): supervisor_mode<=SPP, SIE<=SPIE, SPIE<=1, SPP<=0.
- Counters:
  - wrap modulo 2^CNT_WIDTH
  - cycle increments every non-reset cycle
  - instret increments on inst_retire
  - hpm[i] increments on hpm_event[i]
  - time increments once per rising edge of timer_tick
- STIP comparison: unsigned CNT_WIDTH compare against zero-extended stimecmp; stimecmp halves are written independently.
- Interrupt request:
  - pend = sip & sie.
  - irq_pending = |pend && (!supervisor_mode || SIE).
  - Priority SEI(9) > SSI(1) > STI(5).
  - irq_cause = 32'h8000_0000 | code; irq_cause = 0 when nothing is pending.
  - Latency: combinational from state, so a CSR write that enables an interrupt asserts irq_pending the cycle after the write.

Decomposition:
- cpu_csr_pkg holds:
  - all CSR address constants
  - op encodings
  - sstatus/sip bit indices
  - interrupt codes (1, 5, 9) and the interrupt-cause MSB constant
  - the scounteren index for cycle/time/instret
- Sub-module cpu_csr_counter (parameter WIDTH; ports clk, rst, inc, value) is instantiated for cycle, time, instret and a generate loop of HPM_COUNT hpm counters.

Test Plan:
1. rst, then 10 idle cycles -> cycle reads 10 at C00, C80 reads 0; supervisor_mode=1; rd_data at stvec=0.
2. Write stvec=0x8000_0001 (VECTORED=1); trap with trap_cause=0x8000_0005, trap_pc=0x123 -> handler_addr=0x8000_0014 before the edge; after the edge sepc=0x122, SPP=1, SIE=0.
3. Clear SPP, then sret -> U-mode. Read 100 -> access_ok=0. Read C00 with scounteren=0 -> access_ok=0. Set scounteren=1 -> C00 readable, C01 still access_ok=0.
4. Write stimecmp=5, stimecmph=0; set sie bit 5; SIE=1; 5 timer_tick pulses -> after the 5th rising edge sip bit 5=1, irq_pending=1, irq_cause=0x8000_0005.
5. ext_irq=1, SSIP set, sie=0x222 -> irq_cause=0x8000_0009; drop ext_irq -> 0x8000_0001.
6. Write sepc=0xAAA0 and trap (trap_pc=0x40) in the same cycle -> sepc=0x40. Assert rst during the trap -> all reset values, supervisor_mode=1.

Source files
------------

// File: rtl/cpu_csr_pkg.sv
// Shared constants for the supervisor CSR file: addresses, op encodings,
// status/interrupt bit positions and the read-modify-write helper.
package cpu_csr_pkg;

    localparam logic [11:0] CSR_CYCLE      = 12'hC00;
    localparam logic [11:0] CSR_TIME       = 12'hC01;
    localparam logic [11:0] CSR_INSTRET    = 12'hC02;
    localparam logic [11:0] CSR_HPM_FIRST  = 12'hC03;
    localparam logic [11:0] CSR_CYCLEH     = 12'hC80;
    localparam logic [11:0] CSR_TIMEH      = 12'hC81;
    localparam logic [11:0] CSR_INSTRETH   = 12'hC82;
    localparam logic [11:0] CSR_SSTATUS    = 12'h100;
    localparam logic [11:0] CSR_SIE        = 12'h104;
    localparam logic [11:0] CSR_STVEC      = 12'h105;
    localparam logic [11:0] CSR_SCOUNTEREN = 12'h106;
    localparam logic [11:0] CSR_SSCRATCH   = 12'h140;
    localparam logic [11:0] CSR_SEPC       = 12'h141;
    localparam logic [11:0] CSR_SCAUSE     = 12'h142;
    localparam logic [11:0] CSR_STVAL      = 12'h143;
    localparam logic [11:0] CSR_SIP        = 12'h144;
    localparam logic [11:0] CSR_STIMECMP   = 12'h14D;
    localparam logic [11:0] CSR_STIMECMPH  = 12'h15D;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } csr_op_e;

    localparam int SSTATUS_SIE  = 1;
    localparam int SSTATUS_SPIE = 5;
    localparam int SSTATUS_SPP  = 8;
    localparam int SIP_SSIP     = 1;
    localparam int SIP_STIP     = 5;
    localparam int SIP_SEIP     = 9;

    localparam logic [31:0] IRQ_CODE_SSI  = 32'd1;
    localparam logic [31:0] IRQ_CODE_STI  = 32'd5;
    localparam logic [31:0] IRQ_CODE_SEI  = 32'd9;
    localparam logic [31:0] IRQ_CAUSE_MSB = 32'h8000_0000;
    localparam logic [31:0] SIE_MASK      = 32'h0000_0222;

    localparam int SCEN_CY = 0;
    localparam int SCEN_TM = 1;
    localparam int SCEN_IR = 2;

    // New CSR value for a write/set/clear against the pre-op value.
    function automatic logic [31:0] csr_apply(input logic [1:0] op,
                                              input logic [31:0] old,
                                              input logic [31:0] operand);
        case (csr_op_e'(op))
            OP_WRITE: return operand;
            OP_SET:   return old | operand;
            OP_CLEAR: return old & ~operand;
            default:  return old;
        endcase
    endfunction

endpackage

// File: rtl/cpu_csr_counter.sv
// Free-running wrap-around event counter with synchronous clear.
module cpu_csr_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    // Count one per enabled cycle, modulo 2^WIDTH.
    always_ff @(posedge clk) begin
        if (rst)      value <= '0;
        else if (inc) value <= value + WIDTH'(1);
    end

endmodule

// File: rtl/cpu_csr_file.sv
// Supervisor CSR file: counters, trap entry/return state, interrupt
// pending/enable with stimecmp timer, and scounteren access gating.
module cpu_csr_file
    import cpu_csr_pkg::*;
#(
    parameter int CNT_WIDTH = 64,
    parameter int HPM_COUNT = 4,
    parameter int VECTORED  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] addr,
    input  logic [1:0]  op,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        access_ok,
    input  logic        inst_retire,
    input  logic        timer_tick,
    input  logic [(HPM_COUNT > 0 ? HPM_COUNT : 1)-1:0] hpm_event,
    input  logic        ext_irq,
    input  logic        trap,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_value,
    input  logic        trap_ret,
    output logic [31:0] handler_addr,
    output logic [31:0] return_addr,
    output logic        irq_pending,
    output logic [31:0] irq_cause,
    output logic        supervisor_mode
);

    localparam int HPM_W = (HPM_COUNT > 0) ? HPM_COUNT : 1;
    localparam logic [31:0] SCEN_MASK = 32'((64'd1 << (3 + HPM_COUNT)) - 64'd1);

    logic [CNT_WIDTH-1:0] cyc_val, time_val, ins_val;
    logic [CNT_WIDTH-1:0] hpm_val [HPM_W];
    logic                 tick_q;

    logic        sie_b, spie, spp;
    logic [31:0] sie_r, stvec, sscratch, sepc, scause, stval, scounteren;
    logic        ssip;
    logic [63:0] stimecmp;

    logic        stip;
    logic [31:0] sip_val, sstatus_val, nv, pend;
    logic        is_cnt, impl;
    logic [4:0]  cidx;
    logic [CNT_WIDTH-1:0] cval;
    logic [63:0] cnt_full;

    cpu_csr_counter #(.WIDTH(CNT_WIDTH)) u_cycle (
        .clk(clk), .rst(rst), .inc(1'b1), .value(cyc_val));
    cpu_csr_counter #(.WIDTH(CNT_WIDTH)) u_time (
        .clk(clk), .rst(rst), .inc(timer_tick & ~tick_q), .value(time_val));
    cpu_csr_counter #(.WIDTH(CNT_WIDTH)) u_instret (
        .clk(clk), .rst(rst), .inc(inst_retire), .value(ins_val));

    generate
        if (HPM_COUNT > 0) begin : g_hpm
            for (genvar i = 0; i < HPM_COUNT; i++) begin : g_cnt
                cpu_csr_counter #(.WIDTH(CNT_WIDTH)) u_hpm (
                    .clk(clk), .rst(rst), .inc(hpm_event[i]), .value(hpm_val[i]));
            end
        end else begin : g_no_hpm
            assign hpm_val[0] = '0;
        end
    endgenerate

    assign stip        = 64'(time_val) >= stimecmp;
    assign sip_val     = (32'(ext_irq) << SIP_SEIP) | (32'(stip) << SIP_STIP) |
                         (32'(ssip) << SIP_SSIP);
    assign sstatus_val = (32'(spp) << SSTATUS_SPP) | (32'(spie) << SSTATUS_SPIE) |
                         (32'(sie_b) << SSTATUS_SIE);
    assign return_addr = sepc;
    assign nv          = csr_apply(op, rd_data, wr_data);

    // Address decode, pre-op read value and access legality.
    always_comb begin
        rd_data  = '0;
        impl     = 1'b0;
        cval     = '0;
        cidx     = addr[4:0];
        is_cnt   = (addr[11:8] == 4'hC) && (addr[6:5] == 2'b00) &&
                   (int'(addr[4:0]) < 3 + HPM_COUNT);
        case (cidx)
            5'd0:    cval = cyc_val;
            5'd1:    cval = time_val;
            5'd2:    cval = ins_val;
            default: for (int i = 0; i < HPM_COUNT; i++)
                         if (cidx == 5'(3 + i)) cval = hpm_val[i];
        endcase
        cnt_full = 64'(cval);
        if (is_cnt) begin
            impl    = 1'b1;
            rd_data = addr[7] ? cnt_full[63:32] : cnt_full[31:0];
        end else begin
            impl = 1'b1;
            case (addr)
                CSR_SSTATUS:    rd_data = sstatus_val;
                CSR_SIE:        rd_data = sie_r;
                CSR_STVEC:      rd_data = stvec;
                CSR_SCOUNTEREN: rd_data = scounteren;
                CSR_SSCRATCH:   rd_data = sscratch;
                CSR_SEPC:       rd_data = sepc;
                CSR_SCAUSE:     rd_data = scause;
                CSR_STVAL:      rd_data = stval;
                CSR_SIP:        rd_data = sip_val;
                CSR_STIMECMP:   rd_data = stimecmp[31:0];
                CSR_STIMECMPH:  rd_data = stimecmp[63:32];
                default:        impl    = 1'b0;
            endcase
        end
        access_ok = impl;
        if (addr[9:8] == 2'b01 && !supervisor_mode)                 access_ok = 1'b0;
        if (op != OP_NONE && addr[11:10] == 2'b11)                  access_ok = 1'b0;
        if (is_cnt && !supervisor_mode && !scounteren[cidx])        access_ok = 1'b0;
    end

    // Trap target: vectored mode offsets interrupts by 4*cause code.
    always_comb begin
        handler_addr = {stvec[31:2], 2'b00};
        if (stvec[1:0] == 2'b01 && trap_cause[31])
            handler_addr = {stvec[31:2], 2'b00} + {25'd0, trap_cause[4:0], 2'b00};
    end

    // Enabled-interrupt request with fixed priority SEI > SSI > STI.
    always_comb begin
        pend        = sip_val & sie_r;
        irq_pending = (|pend) && (!supervisor_mode || sie_b);
        irq_cause   = '0;
        if      (pend[SIP_SEIP]) irq_cause = IRQ_CAUSE_MSB | IRQ_CODE_SEI;
        else if (pend[SIP_SSIP]) irq_cause = IRQ_CAUSE_MSB | IRQ_CODE_SSI;
        else if (pend[SIP_STIP]) irq_cause = IRQ_CAUSE_MSB | IRQ_CODE_STI;
    end

    // CSR writes, then trap entry / sret which override overlapping fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            sie_b <= 1'b0; spie <= 1'b0; spp <= 1'b0;
            sie_r <= '0; ssip <= 1'b0; stvec <= '0; sscratch <= '0;
            sepc <= '0; scause <= '0; stval <= '0; scounteren <= '0;
            stimecmp <= '1; supervisor_mode <= 1'b1; tick_q <= 1'b0;
        end else begin
            tick_q <= timer_tick;
            if (op != OP_NONE && access_ok) begin
                case (addr)
                    CSR_SSTATUS: begin
                        sie_b <= nv[SSTATUS_SIE];
                        spie  <= nv[SSTATUS_SPIE];
                        spp   <= nv[SSTATUS_SPP];
                    end
                    CSR_SIE:        sie_r      <= nv & SIE_MASK;
                    CSR_STVEC:      stvec      <= {nv[31:2],
                                       (nv[1:0] == 2'b01 && VECTORED != 0) ? 2'b01 : 2'b00};
                    CSR_SCOUNTEREN: scounteren <= nv & SCEN_MASK;
                    CSR_SSCRATCH:   sscratch   <= nv;
                    CSR_SEPC:       sepc       <= {nv[31:1], 1'b0};
                    CSR_SCAUSE:     scause     <= nv;
                    CSR_STVAL:      stval      <= nv;
                    CSR_SIP:        ssip       <= nv[SIP_SSIP];
                    CSR_STIMECMP:   stimecmp[31:0]  <= nv;
                    CSR_STIMECMPH:  stimecmp[63:32] <= nv;
                    default: ;
                endcase
            end
            if (trap) begin
                sepc            <= {trap_pc[31:1], 1'b0};
                scause          <= trap_cause;
                stval           <= trap_value;
                spp             <= supervisor_mode;
                spie            <= sie_b;
                sie_b           <= 1'b0;
                supervisor_mode <= 1'b1;
            end else if (trap_ret) begin
                supervisor_mode <= spp;
                sie_b           <= spie;
                spie            <= 1'b1;
                spp             <= 1'b0;
            end
        end
    end

endmodule
